// File: rtl/axi_10g_ethernet_0_tx_arbiter.sv
// Merges the TCP control-frame (link) and user-data streams onto the MAC TX
// AXI-Stream. Grants are frame-atomic. Link frames have priority, but after
// MAX_LINK_BURST consecutive link frames the pending user frame is forced in.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no grant; arbitrate on tcp_link_en / tcp_user_en
// GNT_LINK | link stream passed through to tx_axis until its tlast beat
// GNT_USER | user stream passed through to tx_axis until its tlast beat
module axi_10g_ethernet_0_tx_arbiter #(
   parameter int MAX_LINK_BURST = 4,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                 aclk,
   input  logic                 aresetn,
   input  logic [63:0]          tcp_link_tdata,
   input  logic [7:0]           tcp_link_tkeep,
   input  logic                 tcp_link_tvalid,
   input  logic                 tcp_link_tlast,
   output logic                 tcp_link_tready,
   input  logic                 tcp_link_en,
   input  logic [63:0]          tcp_user_tdata,
   input  logic [7:0]           tcp_user_tkeep,
   input  logic                 tcp_user_tvalid,
   input  logic                 tcp_user_tlast,
   output logic                 tcp_user_tready,
   input  logic                 tcp_user_en,
   output logic [63:0]          tx_axis_tdata,
   output logic [7:0]           tx_axis_tkeep,
   output logic                 tx_axis_tvalid,
   output logic                 tx_axis_tlast,
   input  logic                 tx_axis_tready,
   output logic                 grant_link,
   output logic                 grant_user,
   output logic [CNT_WIDTH-1:0] link_frame_cnt,
   output logic [CNT_WIDTH-1:0] user_frame_cnt
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      GNT_LINK = 2'd1,
      GNT_USER = 2'd2
   } state_t;

   localparam int                BW        = $clog2(MAX_LINK_BURST + 1);
   localparam logic [BW-1:0]     BURST_MAX = BW'(MAX_LINK_BURST);

   state_t          state, state_nxt;
   logic            started;
   logic [BW-1:0]   burst_cnt;
   logic            user_starve;
   logic            link_fire, user_fire, link_done, user_done;

   assign user_starve = (burst_cnt == BURST_MAX) && tcp_user_en;
   assign link_fire   = (state == GNT_LINK) && tcp_link_tvalid && tx_axis_tready;
   assign user_fire   = (state == GNT_USER) && tcp_user_tvalid && tx_axis_tready;
   assign link_done   = link_fire && tcp_link_tlast;
   assign user_done   = user_fire && tcp_user_tlast;

   // State register; reset drops any grant immediately, truncating the frame.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) state <= IDLE;
      else          state <= state_nxt;
   end

   // Next-state: arbitrate in IDLE, hold grant until tlast or pre-beat withdraw.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (tcp_link_en && !user_starve) state_nxt = GNT_LINK;
            else if (tcp_user_en)            state_nxt = GNT_USER;
         end
         GNT_LINK: begin
            if (link_done)                                 state_nxt = IDLE;
            else if (!link_fire && !started && !tcp_link_en) state_nxt = IDLE;
         end
         GNT_USER: begin
            if (user_done)                                 state_nxt = IDLE;
            else if (!user_fire && !started && !tcp_user_en) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs: combinational pass-through of the granted source, zero in IDLE.
   always_comb begin
      tx_axis_tdata   = '0;
      tx_axis_tkeep   = '0;
      tx_axis_tvalid  = 1'b0;
      tx_axis_tlast   = 1'b0;
      tcp_link_tready = 1'b0;
      tcp_user_tready = 1'b0;
      grant_link      = 1'b0;
      grant_user      = 1'b0;
      case (state)
         GNT_LINK: begin
            tx_axis_tdata   = tcp_link_tdata;
            tx_axis_tkeep   = tcp_link_tkeep;
            tx_axis_tvalid  = tcp_link_tvalid;
            tx_axis_tlast   = tcp_link_tlast;
            tcp_link_tready = tx_axis_tready;
            grant_link      = 1'b1;
         end
         GNT_USER: begin
            tx_axis_tdata   = tcp_user_tdata;
            tx_axis_tkeep   = tcp_user_tkeep;
            tx_axis_tvalid  = tcp_user_tvalid;
            tx_axis_tlast   = tcp_user_tlast;
            tcp_user_tready = tx_axis_tready;
            grant_user      = 1'b1;
         end
         default: ;
      endcase
   end

   // Marks that the granted frame has moved at least one beat; after that the
   // request level is ignored until tlast.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)                 started <= 1'b0;
      else if (state_nxt == IDLE)   started <= 1'b0;
      else if (link_fire || user_fire) started <= 1'b1;
   end

   // Consecutive link frames seen while a user frame waits, saturating.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)
         burst_cnt <= '0;
      else if (user_done)
         burst_cnt <= '0;
      else if (link_done && tcp_user_en && (burst_cnt != BURST_MAX))
         burst_cnt <= burst_cnt + BW'(1);
      else if ((state == IDLE) && !tcp_user_en)
         burst_cnt <= '0;
   end

   // Completed-frame counters, wrapping naturally.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         link_frame_cnt <= '0;
         user_frame_cnt <= '0;
      end else begin
         if (link_done) link_frame_cnt <= link_frame_cnt + CNT_WIDTH'(1);
         if (user_done) user_frame_cnt <= user_frame_cnt + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_axi_10g_ethernet_0_tx_arbiter.sv
// Bench for the TX arbiter: directed scenarios followed by random traffic,
// all outputs compared every cycle against a frame-level ownership model.
module tb_axi_10g_ethernet_0_tx_arbiter;

   localparam int MAXB = 4;
   localparam int CW   = 4;
   localparam int CMASK = (1 << CW) - 1;

   logic          aclk = 1'b0;
   logic          aresetn = 1'b0;
   logic [63:0]   l_data = '0, u_data = '0;
   logic [7:0]    l_keep = '0, u_keep = '0;
   logic          l_valid = 1'b0, l_last = 1'b0, l_en = 1'b0;
   logic          u_valid = 1'b0, u_last = 1'b0, u_en = 1'b0;
   logic          txr = 1'b0;
   logic          l_rdy, u_rdy, tx_valid, tx_last, g_link, g_user;
   logic [63:0]   tx_data;
   logic [7:0]    tx_keep;
   logic [CW-1:0] l_cnt, u_cnt;

   axi_10g_ethernet_0_tx_arbiter #(.MAX_LINK_BURST(MAXB), .CNT_WIDTH(CW)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .tcp_link_tdata(l_data), .tcp_link_tkeep(l_keep), .tcp_link_tvalid(l_valid),
      .tcp_link_tlast(l_last), .tcp_link_tready(l_rdy), .tcp_link_en(l_en),
      .tcp_user_tdata(u_data), .tcp_user_tkeep(u_keep), .tcp_user_tvalid(u_valid),
      .tcp_user_tlast(u_last), .tcp_user_tready(u_rdy), .tcp_user_en(u_en),
      .tx_axis_tdata(tx_data), .tx_axis_tkeep(tx_keep), .tx_axis_tvalid(tx_valid),
      .tx_axis_tlast(tx_last), .tx_axis_tready(txr),
      .grant_link(g_link), .grant_user(g_user),
      .link_frame_cnt(l_cnt), .user_frame_cnt(u_cnt)
   );

   always #5 aclk = ~aclk;

   int n_chk = 0;
   int n_pass = 0;

   // Reference model: who owns the bus, whether the frame has moved, counts.
   int owner = 0;   // 0 none, 1 link, 2 user
   bit began = 1'b0;
   int burst = 0;
   int lcnt = 0;
   int ucnt = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic model_reset();
      owner = 0; began = 1'b0; burst = 0; lcnt = 0; ucnt = 0;
   endtask

   task automatic check_outputs();
      logic [63:0] ed = '0;
      logic [7:0]  ek = '0;
      logic        ev = 1'b0, el = 1'b0;
      if (owner == 1) begin ed = l_data; ek = l_keep; ev = l_valid; el = l_last; end
      if (owner == 2) begin ed = u_data; ek = u_keep; ev = u_valid; el = u_last; end
      chk("tx_tdata",   tx_data,         ed);
      chk("tx_tkeep",   64'(tx_keep),    64'(ek));
      chk("tx_tvalid",  64'(tx_valid),   64'(ev));
      chk("tx_tlast",   64'(tx_last),    64'(el));
      chk("grant_link", 64'(g_link),     64'(owner == 1));
      chk("grant_user", 64'(g_user),     64'(owner == 2));
      chk("link_tready",64'(l_rdy),      64'((owner == 1) && txr));
      chk("user_tready",64'(u_rdy),      64'((owner == 2) && txr));
      chk("link_cnt",   64'(l_cnt),      64'(lcnt & CMASK));
      chk("user_cnt",   64'(u_cnt),      64'(ucnt & CMASK));
   endtask

   task automatic model_step();
      bit fire, last, en;
      if (owner == 0) begin
         if (!u_en) burst = 0;
         if (l_en && !(burst == MAXB && u_en)) owner = 1;
         else if (u_en) owner = 2;
      end else begin
         fire = (owner == 1 ? l_valid : u_valid) && txr;
         last = (owner == 1) ? l_last : u_last;
         en   = (owner == 1) ? l_en : u_en;
         if (fire && last) begin
            if (owner == 1) begin
               lcnt++;
               if (u_en && burst < MAXB) burst++;
            end else begin
               ucnt++;
               burst = 0;
            end
            owner = 0;
            began = 1'b0;
         end else if (fire) begin
            began = 1'b1;
         end else if (!began && !en) begin
            owner = 0;
         end
      end
   endtask

   task automatic drive(input bit len, input bit lv, input bit ll,
                        input bit uen, input bit uv, input bit ul, input bit r);
      l_en = len; l_valid = lv; l_last = ll;
      u_en = uen; u_valid = uv; u_last = ul;
      txr = r;
      l_data = {$urandom, $urandom}; l_keep = 8'($urandom);
      u_data = {$urandom, $urandom}; u_keep = 8'($urandom);
   endtask

   // Check this cycle's outputs, then advance DUT and model across one edge.
   task automatic tick();
      #1 check_outputs();
      @(posedge aclk);
      model_step();
      #1;
   endtask

   int lc0, k, prev_u;
   bit seen_user, resumed, fired, r;

   initial begin
      #1 check_outputs();
      chk("reset_link_cnt", 64'(l_cnt), 64'(0));
      @(posedge aclk);
      #1 aresetn = 1'b1;

      // Link only, 3-beat frame
      drive(1,0,0,0,0,0,1); tick();
      chk("s32_grant", 64'(g_link), 64'(1));
      drive(1,1,0,0,0,0,1); tick();
      drive(1,1,0,0,0,0,1); tick();
      drive(1,1,1,0,0,0,1); tick();
      chk("s32_idle", 64'(g_link), 64'(0));
      chk("s32_cnt", 64'(l_cnt), 64'(1));
      drive(0,0,0,0,0,0,1); tick();

      // Simultaneous requests: link first, user after one bubble
      drive(1,0,0,1,0,0,1); tick();
      chk("s33_link_first", 64'(g_link), 64'(1));
      drive(1,1,0,1,0,0,1); tick();
      drive(1,1,1,1,0,0,1); tick();
      chk("s33_bubble", 64'({g_link, g_user}), 64'(0));
      drive(0,0,0,1,0,0,1); tick();
      chk("s33_user", 64'(g_user), 64'(1));
      drive(0,0,0,1,1,1,1); tick();
      chk("s33_ucnt", 64'(u_cnt), 64'(1));
      drive(0,0,0,0,0,0,1); tick();

      // Starvation: both requests held, one-beat frames
      lc0 = int'(l_cnt); seen_user = 0; resumed = 0;
      for (int c = 0; c < 24; c++) begin
         drive(1,1,1,1,1,1,1); tick();
         if (g_user && !seen_user) begin
            seen_user = 1;
            chk("s34_links_before_user", 64'((int'(l_cnt) - lc0) & CMASK), 64'(MAXB));
         end else if (seen_user && g_link) resumed = 1;
      end
      chk("s34_user_seen", 64'(seen_user), 64'(1));
      chk("s34_link_resumes", 64'(resumed), 64'(1));
      drive(0,0,0,0,0,0,1); tick();
      drive(0,0,0,0,0,0,1); tick();

      // Backpressure mid user frame, link request arriving
      drive(0,0,0,1,0,0,1); tick();
      chk("s35_grant", 64'(g_user), 64'(1));
      k = 0; r = 0;
      for (int c = 0; c < 40 && k < 4; c++) begin
         drive(c > 0, 1, 0, 1, 1, k == 3, r);
         u_data = 64'hA0 + 64'(k);
         #1;
         chk("s35_link_tready", 64'(l_rdy), 64'(0));
         fired = tx_valid && txr;
         if (fired) chk("s35_order", tx_data, 64'hA0 + 64'(k));
         tick();
         if (fired) k++;
         r = !r;
      end
      chk("s35_beats", 64'(k), 64'(4));
      drive(0,0,0,0,0,0,1); tick();

      // Early withdraw of user request before first beat
      prev_u = int'(u_cnt);
      drive(0,0,0,1,0,0,1); tick();
      chk("s36_grant", 64'(g_user), 64'(1));
      drive(0,0,0,0,0,0,1); tick();
      chk("s36_idle", 64'(g_user), 64'(0));
      chk("s36_ucnt", 64'(u_cnt), 64'(prev_u));

      // Reset on beat 2 of a 5-beat link frame
      drive(1,0,0,0,0,0,1); tick();
      drive(1,1,0,0,0,0,1); tick();
      drive(1,1,0,0,0,0,1);
      #1 aresetn = 1'b0;
      #1;
      chk("s37_tvalid", 64'(tx_valid), 64'(0));
      chk("s37_grant", 64'({g_link, g_user}), 64'(0));
      chk("s37_tready", 64'({l_rdy, u_rdy}), 64'(0));
      chk("s37_cnts", 64'({l_cnt, u_cnt}), 64'(0));
      model_reset();
      @(posedge aclk);
      #1 aresetn = 1'b1;
      drive(1,0,0,0,0,0,1); tick();
      chk("s37_regrant", 64'(g_link), 64'(1));
      drive(1,1,1,0,0,0,1); tick();
      chk("s37_cnt", 64'(l_cnt), 64'(1));

      // Random traffic against the model
      for (int c = 0; c < 3000; c++) begin
         drive($urandom_range(0,3) != 0, $urandom_range(0,3) != 0, $urandom_range(0,2) == 0,
               $urandom_range(0,2) != 0, $urandom_range(0,3) != 0, $urandom_range(0,2) == 0,
               $urandom_range(0,3) != 0);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/axi_10g_ethernet_0_tx_arbiter.md
AXI_10G_ETHERNET_0_TX_ARBITER -- requirements
Module: axi_10g_ethernet_0_tx_arbiter

Interface
REQ-001 SHALL have parameter MAX_LINK_BURST, default 4: maximum consecutive link frames granted while user is requesting.
REQ-002 SHALL have parameter CNT_WIDTH, default 16: width of the frame counters.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 aclk  in  1  sole clock; all state on rising edge.
REQ-005 aresetn  in  1  asynchronous active-low reset.
REQ-006 tcp_link_tdata/tkeep/tvalid/tlast  in  64/8/1/1  control-frame stream (SYN/ACK/FIN) from generator.
REQ-007 tcp_link_tready  out  1  ready to the link stream.
REQ-008 tcp_link_en  in  1  level request: link frame pending.
REQ-009 tcp_user_tdata/tkeep/tvalid/tlast  in  64/8/1/1  user-data frame stream.
REQ-010 tcp_user_tready  out  1  ready to the user stream.
REQ-011 tcp_user_en  in  1  level request: user frame pending.
REQ-012 tx_axis_tdata/tkeep/tvalid/tlast  out  64/8/1/1  merged stream to the MAC TX.
REQ-013 tx_axis_tready  in  1  MAC backpressure.
REQ-014 grant_link, grant_user  out  1 each  one-hot current grant.
REQ-015 link_frame_cnt, user_frame_cnt  out  CNT_WIDTH  frames completed per source.

Function
REQ-016 SHALL implement states IDLE, GNT_LINK, GNT_USER.
REQ-017 IDLE: when tcp_link_en is high and not (user_starve), next state SHALL be GNT_LINK; else if tcp_user_en is high, next state SHALL be GNT_USER; else stay IDLE.
REQ-018 user_starve SHALL be true when burst_cnt == MAX_LINK_BURST and tcp_user_en is high; it SHALL force GNT_USER even if tcp_link_en is high.
REQ-019 burst_cnt SHALL increment on each completed link frame while tcp_user_en is high, saturate at MAX_LINK_BURST, and clear on any completed user frame or when tcp_user_en is low in IDLE.
REQ-020 In a grant state, tx_axis_* SHALL be combinational copies of the selected source, and the selected tready SHALL equal tx_axis_tready.
REQ-021 The unselected source's tready SHALL be 0.
REQ-022 In IDLE, tx_axis_tvalid, both treadys and both grants SHALL be 0.
REQ-023 Grant latency: a request seen in IDLE at cycle N SHALL produce a grant and pass-through at cycle N+1.
REQ-024 A frame completes on a beat with tvalid & tready & tlast; the state SHALL return to IDLE on the next cycle (one idle bubble between frames).
REQ-025 Grants SHALL be frame-atomic: no switch mid-frame regardless of the other request.
REQ-026 If the granted en drops before any beat of the frame is transferred, the block SHALL return to IDLE without counting a frame; after the first beat, en is ignored until tlast.
REQ-027 Frame counters SHALL increment by 1 on each completed frame of their source and wrap modulo 2^CNT_WIDTH.
REQ-028 Simultaneous link and user requests in IDLE with no starvation SHALL grant link.

Reset
REQ-029 On aresetn low: state IDLE, burst_cnt 0, both counters 0, all outputs 0, asynchronously.
REQ-030 Reset asserted mid-frame SHALL drop the grant immediately and leave the frame truncated; no recovery attempt is made.
REQ-031 After deassertion, arbitration SHALL begin on the first rising edge with aresetn high.

Verification
REQ-032 Link only: 3-beat link frame with tx_axis_tready=1 -> grant_link at N+1, 3 beats out, IDLE at N+4, link_frame_cnt=1.
REQ-033 Simultaneous en: both request -> link frame first, then user frame after one bubble; user_frame_cnt=1.
REQ-034 Starvation: link_en held high and user_en high, MAX_LINK_BURST=4 -> exactly 4 link frames, then 1 user frame, then link resumes.
REQ-035 Backpressure: tx_axis_tready toggles every cycle mid user frame, link_en rises -> no switch, tcp_link_tready stays 0, all user beats delivered in order.
REQ-036 Early withdraw: user granted, tcp_user_en drops before first beat -> IDLE next cycle, user_frame_cnt unchanged.
REQ-037 Reset mid-frame: aresetn low on beat 2 of 5 -> outputs 0 in the same cycle, counters 0, fresh request after release granted normally.
